life_cell_update: RTL and testbench
===================================

# life_cell_update

Downstream of `memory_control`, this block turns its nine per-memory read words into the next generation of the Game of Life.
- Takes the nine one-bit words read from the block-interleaved cell memories.
- Masks out-of-bounds neighbours.
- Applies the B3/S23 rule.
- Issues the aligned write (enable, address, data) into the back frame buffer.
- Also keeps per-frame population and generation statistics.

## Interface
- `ADDR_WIDTH`, 2, memory address width
- `READ_LATENCY`, 1, memory read latency in cycles (≥1)
- `POP_WIDTH`, 16, population counter width
- `GEN_WIDTH`, 16, generation counter width
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `enable`  in  1  address beat valid (same `enable` driving `memory_control`)
- `read_enable`  in  9  per-memory in-bounds mask, cycle of address issue
- `write_enable_in`  in  9  one-hot centre-memory select, cycle of address issue
- `write_addr_in`  in  `ADDR_WIDTH`  centre write address, cycle of address issue
- `frame_buffer_select_in`  in  1  frame buffer select, cycle of address issue
- `read_data`  in  9  memory k output bit, valid `READ_LATENCY` cycles after issue
- `write_enable_out`  out  9  registered write strobe per memory
- `write_addr_out`  out  `ADDR_WIDTH`  registered write address
- `write_data`  out  1  next state of centre cell
- `frame_buffer_select_out`  out  1  select aligned to the write beat
- `population`  out  `POP_WIDTH`  live cells in last completed frame
- `generation`  out  `GEN_WIDTH`  completed frame count
- `frame_done`  out  1  one-cycle pulse when a frame completes

## Operation
- **Issue stage:** `enable`, `read_enable`, `write_enable_in`, `write_addr_in` and `frame_buffer_select_in` enter a `READ_LATENCY`-deep delay line, so they line up with `read_data`.
- **Eval stage** (delayed valid = 1):
  - `masked = read_data & read_enable_d`.
  - `centre = |(masked & write_enable_d)`.
  - `n = popcount(masked & ~write_enable_d)`, 4 bits, range 0..8.
  - `next = (n==3) | (centre & n==2)`.
- **Output register:**
  - When the delayed valid is 1: `write_enable_out = write_enable_d`, `write_addr_out = write_addr_d`, `write_data = next`, `frame_buffer_select_out = fbs_d`.
  - When the delayed valid is 0: `write_enable_out = 0`; the address and data outputs hold their previous values.
- **Out-of-bounds memories** (`read_enable` low) count as dead regardless of `read_data`.
- **`write_enable_in` rules:**
  - Exactly one bit is expected set.
  - If more than one bit is set, every selected memory is still written with the same `write_data`.
  - If all bits are zero, centre = 0 and nothing is written.
- **Frame boundary:** a valid output beat whose `fbs_d` differs from the previous valid beat's select ends the frame. On that cycle:
  - `population` takes the accumulator value.
  - The accumulator restarts with the current beat's `next`.
  - `generation` increments, wrapping at 2^`GEN_WIDTH`.
  - `frame_done` pulses.
- **Accumulator:** adds 1 per valid beat with `next = 1` and saturates at all-ones.

## Timing
- Latency from address issue (`enable` = 1) to `write_enable_out`: `READ_LATENCY`+1 cycles. Throughput is one cell per cycle.
- `enable` low inserts bubbles; bubbles propagate, and no write occurs for them.
- **Reset values:** all outputs 0, the delay line cleared (no writes), accumulator 0, previous select 0.
- The first valid beat after reset never triggers `frame_done`; a "seen first beat" flag gates it.
- **Reset mid-frame:** in-flight beats are dropped; the partial population is discarded and not latched.
- `population`, `generation` and `frame_done` are registered and change on the same edge.

## Configuration
- **`CONWAY_STATS_EN` defined:** the accumulator, `population`, `generation` and `frame_done` logic are compiled in.
- **`CONWAY_STATS_EN` undefined:** that logic is removed; `population`, `generation` and `frame_done` are tied to 0. The write path is identical in both cases.

## Structure
- Shared package `conway_pkg`:
  - `NUM_MEMS` = 9
  - `CENTRE_IDX` = 4
  - `BIRTH_MASK` = 9'b000001000
  - `SURVIVE_MASK` = 9'b000001100, indexed by neighbour count
  - typedef `mem_vec_t` (logic [8:0])
- Sub-module `pipe_delay`: a parameterised width/depth register chain with asynchronous active-low clear. It is instantiated once for the concatenated issue-stage control bundle.
- The popcount stays inline.

## Test plan
- **Blinker:** `read_data` = 9'b000111000, `read_enable` = all 1, `write_enable_in` = bit 4, `enable` = 1 → 2 cycles later `write_enable_out` = bit 4, `write_data` = 1 (n=2, survive).
- **Birth:** `read_data` = 9'b000001011, centre bit 4 = 0 → `write_data` = 1. With `read_data` = 9'b000001001 → `write_data` = 0.
- **Boundary mask:** `read_data` = 9'b111111111, `read_enable` = 9'b000011011, `write_enable_in` = bit 4 → n = 3, `write_data` = 1.
- **Bubbles/latency:** `enable` pattern 1,0,1 with `READ_LATENCY`=2 → `write_enable_out` nonzero exactly on cycles 3 and 5, zero on cycle 4.
- **Stats:** 36 beats with `frame_buffer_select_in` = 0 and 5 live results, then a beat with select 1 → `frame_done` pulses once, `population` = 5, `generation` = 1. With `CONWAY_STATS_EN` undefined, all three stay 0.
- **Reset mid-stream:** assert `resetn` = 0 with 2 beats in flight → no `write_enable_out` after release until new beats arrive; `population` = 0.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared constants and types for the Game of Life cell-update datapath.
package conway_pkg;
  localparam int NUM_MEMS   = 9;
  localparam int CENTRE_IDX = 4;

  // Indexed by live-neighbour count: bit n set means that count yields a live cell.
  localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
  localparam logic [8:0] SURVIVE_MASK = 9'b000001100;

  typedef logic [NUM_MEMS-1:0] mem_vec_t;

  function automatic logic life_rule(input logic centre, input logic [3:0] n);
    logic [8:0] mask;
    mask = centre ? SURVIVE_MASK : BIRTH_MASK;
    return (n < 4'd9) ? mask[n] : 1'b0;
  endfunction
endpackage

// File: rtl/pipe_delay.sv
// Parameterised register chain with asynchronous active-low clear.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/life_cell_update.sv
// Next-generation evaluation of one cell per cycle with aligned back-buffer write.
// Frame statistics (population/generation/frame_done) are built only with CONWAY_STATS_EN.
module life_cell_update
  import conway_pkg::*;
#(
  parameter int ADDR_WIDTH   = 2,
  parameter int READ_LATENCY = 1,
  parameter int POP_WIDTH    = 16,
  parameter int GEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [8:0]            read_enable,
  input  logic [8:0]            write_enable_in,
  input  logic [ADDR_WIDTH-1:0] write_addr_in,
  input  logic                  frame_buffer_select_in,
  input  logic [8:0]            read_data,
  output logic [8:0]            write_enable_out,
  output logic [ADDR_WIDTH-1:0] write_addr_out,
  output logic                  write_data,
  output logic                  frame_buffer_select_out,
  output logic [POP_WIDTH-1:0]  population,
  output logic [GEN_WIDTH-1:0]  generation,
  output logic                  frame_done
);
  localparam int BW = 1 + 2*NUM_MEMS + ADDR_WIDTH + 1;

  logic [BW-1:0]         bundle_in;
  logic [BW-1:0]         bundle_d;
  logic                  valid_d;
  mem_vec_t              re_d;
  mem_vec_t              we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  fbs_d;

  assign bundle_in = {enable, read_enable, write_enable_in, write_addr_in, frame_buffer_select_in};

  // Control rides alongside the memory read so it lines up with read_data.
  pipe_delay #(.WIDTH(BW), .DEPTH(READ_LATENCY)) u_issue_dly (
    .clk    (clk),
    .resetn (resetn),
    .d      (bundle_in),
    .q      (bundle_d)
  );

  assign {valid_d, re_d, we_d, addr_d, fbs_d} = bundle_d;

  mem_vec_t   masked;
  mem_vec_t   nbr;
  logic       centre;
  logic [3:0] n_live;
  logic       next_state;

  always_comb begin
    masked = read_data & re_d;
    nbr    = masked & ~we_d;
    centre = |(masked & we_d);
    n_live = '0;
    for (int i = 0; i < NUM_MEMS; i++) n_live = n_live + 4'(nbr[i]);
    next_state = life_rule(centre, n_live);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_enable_out        <= '0;
      write_addr_out          <= '0;
      write_data              <= 1'b0;
      frame_buffer_select_out <= 1'b0;
    end else if (valid_d) begin
      write_enable_out        <= we_d;
      write_addr_out          <= addr_d;
      write_data              <= next_state;
      frame_buffer_select_out <= fbs_d;
    end else begin
      write_enable_out <= '0;
    end
  end

`ifdef CONWAY_STATS_EN
  logic                 seen_first;
  logic                 prev_fbs;
  logic [POP_WIDTH-1:0] acc;
  logic                 frame_end;

  assign frame_end = valid_d && seen_first && (fbs_d != prev_fbs);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen_first <= 1'b0;
      prev_fbs   <= 1'b0;
      acc        <= '0;
      population <= '0;
      generation <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (valid_d) begin
        seen_first <= 1'b1;
        prev_fbs   <= fbs_d;
        if (frame_end) begin
          population <= acc;
          acc        <= {{(POP_WIDTH-1){1'b0}}, next_state};
          generation <= generation + 1'b1;
          frame_done <= 1'b1;
        end else if (next_state && acc != '1) begin
          acc <= acc + 1'b1;
        end
      end
    end
  end
`else
  assign population = '0;
  assign generation = '0;
  assign frame_done = 1'b0;
`endif
endmodule

// File: tb/tb_life_cell_update.sv
// Randomised and directed bench for life_cell_update against a rule-level model.
module tb_life_cell_update;
  localparam int AW = 2;
  localparam int RL = 2;
  localparam int PW = 16;
  localparam int GW = 16;

  typedef struct packed {
    logic          en;
    logic [8:0]    re;
    logic [8:0]    we;
    logic [8:0]    rd;
    logic [AW-1:0] addr;
    logic          fbs;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic [8:0]    read_enable = '0;
  logic [8:0]    write_enable_in = '0;
  logic [AW-1:0] write_addr_in = '0;
  logic          frame_buffer_select_in = 1'b0;
  logic [8:0]    read_data = '0;
  logic [8:0]    write_enable_out;
  logic [AW-1:0] write_addr_out;
  logic          write_data;
  logic          frame_buffer_select_out;
  logic [PW-1:0] population;
  logic [GW-1:0] generation;
  logic          frame_done;

  life_cell_update #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .POP_WIDTH(PW), .GEN_WIDTH(GW)) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .enable                  (enable),
    .read_enable             (read_enable),
    .write_enable_in         (write_enable_in),
    .write_addr_in           (write_addr_in),
    .frame_buffer_select_in  (frame_buffer_select_in),
    .read_data               (read_data),
    .write_enable_out        (write_enable_out),
    .write_addr_out          (write_addr_out),
    .write_data              (write_data),
    .frame_buffer_select_out (frame_buffer_select_out),
    .population              (population),
    .generation              (generation),
    .frame_done              (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  beat_t q[$];

  // Reference state
  logic [8:0]    m_we;
  logic [AW-1:0] m_addr;
  logic          m_data, m_fbs;
  bit            m_seen, m_prev, m_done;
  int            m_acc, m_pop, m_gen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t mk(logic en, logic [8:0] re, logic [8:0] we, logic [8:0] rd,
                               logic [AW-1:0] addr, logic fbs);
    beat_t b;
    b.en = en; b.re = re; b.we = we; b.rd = rd; b.addr = addr; b.fbs = fbs;
    return b;
  endfunction

  // Game of Life rule stated directly: count live in-bounds neighbours, check centre.
  function automatic logic life_next(beat_t b);
    int  n = 0;
    bit  c = 0;
    for (int i = 0; i < 9; i++) begin
      if (b.re[i] && b.rd[i]) begin
        if (b.we[i]) c = 1;
        else n++;
      end
    end
    return (n == 3) || (c && n == 2);
  endfunction

  task automatic model_reset();
    m_we = '0; m_addr = '0; m_data = 0; m_fbs = 0;
    m_seen = 0; m_prev = 0; m_done = 0; m_acc = 0; m_pop = 0; m_gen = 0;
  endtask

  task automatic model_step(input beat_t b, input bit valid);
    logic nx;
    m_done = 0;
    if (!(valid && b.en)) begin
      m_we = '0;
      return;
    end
    nx = life_next(b);
    m_we = b.we; m_addr = b.addr; m_data = nx; m_fbs = b.fbs;
    if (m_seen && b.fbs != m_prev) begin
      m_pop = m_acc;
      m_acc = nx;
      m_gen = (m_gen + 1) % (1 << GW);
      m_done = 1;
    end else if (nx && m_acc < (1 << PW) - 1) begin
      m_acc++;
    end
    m_seen = 1;
    m_prev = b.fbs;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".we"}, write_enable_out, m_we);
    chk({ph, ".addr"}, write_addr_out, m_addr);
    chk({ph, ".data"}, write_data, m_data);
    chk({ph, ".fbs"}, frame_buffer_select_out, m_fbs);
`ifdef CONWAY_STATS_EN
    chk({ph, ".pop"}, population, m_pop);
    chk({ph, ".gen"}, generation, m_gen);
    chk({ph, ".done"}, frame_done, m_done);
`else
    chk({ph, ".pop"}, population, 0);
    chk({ph, ".gen"}, generation, 0);
    chk({ph, ".done"}, frame_done, 0);
`endif
  endtask

  task automatic drive_issue(input beat_t b);
    enable = b.en; read_enable = b.re; write_enable_in = b.we;
    write_addr_in = b.addr; frame_buffer_select_in = b.fbs;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    drive_issue(mk(0, '0, '0, '0, '0, 0));
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    resetn = 1'b1;
  endtask

  // Reset, play the queued beats, then drain the pipeline.
  task automatic run_stream(input string ph);
    beat_t idle;
    hard_reset();
    idle = mk(0, 9'($urandom), 9'($urandom), 9'($urandom), AW'($urandom), 0);
    for (int k = 0; k < q.size() + RL; k++) begin
      if (k < q.size()) drive_issue(q[k]);
      else drive_issue(idle);
      read_data = (k >= RL) ? q[k-RL].rd : 9'($urandom);
      @(posedge clk);
      #1;
      if (k >= RL) model_step(q[k-RL], 1);
      else model_step(idle, 0);
      check_outputs(ph);
    end
    q.delete();
  endtask

  initial begin
    beat_t b;
    logic [8:0] we;
    bit fbs;
    model_reset();
    #12;

    // Directed rule cases and a 1,0,1 bubble pattern.
    q.push_back(mk(1, 9'h1FF, 9'b000010000, 9'b000111000, 2'd1, 0)); // blinker: survive
    q.push_back(mk(0, 9'h1FF, 9'b000010000, 9'b000111000, 2'd2, 0)); // bubble
    q.push_back(mk(1, 9'h1FF, 9'b000010000, 9'b000001011, 2'd2, 0)); // birth
    q.push_back(mk(1, 9'h1FF, 9'b000010000, 9'b000001001, 2'd3, 0)); // n=2, dead centre
    q.push_back(mk(1, 9'b000011011, 9'b000010000, 9'h1FF, 2'd0, 0)); // boundary mask n=3
    q.push_back(mk(1, 9'h1FF, 9'b000000000, 9'h1FF, 2'd1, 0));       // no centre: nothing written
    q.push_back(mk(1, 9'h1FF, 9'b000010001, 9'b000001110, 2'd3, 0)); // multi-hot centre
    q.push_back(mk(1, 9'h1FF, 9'b000010000, 9'h1FF, 2'd2, 0));       // overcrowded
    run_stream("dir");

    // One frame of 36 beats with 5 live results, closed by a select change.
    for (int i = 0; i < 36; i++)
      q.push_back(mk(1, 9'h1FF, 9'b000010000, (i % 7 == 3) ? 9'b000111000 : 9'b0, 2'(i), 0));
    q.push_back(mk(1, 9'h1FF, 9'b000010000, 9'b0, 2'd0, 1));
    run_stream("stats");
`ifdef CONWAY_STATS_EN
    chk("stats.pop5", population, 5);
    chk("stats.gen1", generation, 1);
`else
    chk("stats.pop0", population, 0);
    chk("stats.gen0", generation, 0);
`endif

    // Random stream with occasional frame changes.
    fbs = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       we = '0;
        1:       we = 9'($urandom);
        default: we = 9'(1 << $urandom_range(0, 8));
      endcase
      if ($urandom_range(0, 29) == 0) fbs = ~fbs;
      b = mk(($urandom_range(0, 3) != 0), 9'($urandom) | 9'($urandom), we,
             9'($urandom), AW'($urandom), fbs);
      q.push_back(b);
    end
    run_stream("rand");

    // Reset with two beats in flight: they must never emerge.
    @(negedge clk);
    drive_issue(mk(1, 9'h1FF, 9'b000010000, 9'b0, 2'd1, ~frame_buffer_select_out));
    @(negedge clk);
    drive_issue(mk(1, 9'h1FF, 9'b000010000, 9'b0, 2'd2, 0));
    @(posedge clk);
    #1;
    resetn = 1'b0;
    drive_issue(mk(0, '0, '0, '0, '0, 0));
    model_reset();
    #1;
    check_outputs("rstmid");
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_data = 9'h1FF;
      @(posedge clk);
      #1;
      chk("rstmid.we", write_enable_out, 0);
      chk("rstmid.pop", population, 0);
      chk("rstmid.done", frame_done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
